spi_log_packer: RTL

Converts SPI flash transaction events into byte records and streams them out of the UART transmit port. Three record formats are selectable per record: compact, verbose and monitor. Records are buffered in a record FIFO, and backpressure from uart_txd_ready is honoured. User-parser bytes are interleaved only between records. The block sits between spi_flash/spi_device and uart in top, replacing the inline uart_word shifter, and adds an address-match scope trigger.

---
 rtl/spi_log_pkg.sv | 34 +++
 rtl/spi_log_fifo.sv | 64 ++++++
 rtl/spi_log_packer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/spi_log_pkg.sv
// rtl/spi_log_pkg.sv - shared constants, types and helpers for the SPI log packer
package spi_log_pkg;

  localparam logic [1:0] FMT_COMPACT = 2'd0;
  localparam logic [1:0] FMT_VERBOSE = 2'd1;
  localparam logic [1:0] FMT_MONITOR = 2'd2;

  localparam int ENTRY_W = 42;
  localparam int MAX_REC_BYTES = 9;
  localparam logic [31:0] VERBOSE_TAG = "READ";

  // One queued record: format, 32-bit payload word and one trailing byte.
  typedef struct packed {
    logic [1:0]  fmt;
    logic [31:0] a;
    logic [7:0]  b;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // Number of bytes a record of the given format puts on the wire.
  function automatic logic [3:0] record_len(input logic [1:0] fmt, input int addr_bytes);
    case (fmt)
      FMT_VERBOSE: return 4'(addr_bytes + 5);
      FMT_MONITOR: return 4'd4;
      default:     return 4'(addr_bytes + 1);
    endcase
  endfunction

endpackage

// File: rtl/spi_log_fifo.sv
// rtl/spi_log_fifo.sv - single-clock record FIFO with registered full/empty flags
module spi_log_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             wr_ok, rd_ok;

  assign wr_ok   = wr_en && !full_q;
  assign rd_ok   = rd_en && !empty_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

  // Occupancy and the flags derived from it for the next cycle.
  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Storage array; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: rtl/spi_log_packer.sv
// rtl/spi_log_packer.sv - SPI flash event to UART byte record packer with scope trigger
module spi_log_packer
  import spi_log_pkg::*;
#(
  parameter int          ADDR_BYTES     = 3,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [31:0] TRIGGER_ADDR   = 32'h00000010,
  parameter int          TRIGGER_CYCLES = 31,
  parameter int          DROP_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            mode,
  input  logic                  log_strobe,
  input  logic [31:0]           log_addr,
  input  logic [7:0]            log_len,
  input  logic                  mon_strobe,
  input  logic                  mon_cmd,
  input  logic [7:0]            mon_mosi,
  input  logic [7:0]            mon_miso,
  input  logic [7:0]            user_txd,
  input  logic                  user_txd_strobe,
  output logic                  user_txd_ready,
  input  logic                  inhibit,
  output logic [7:0]            uart_txd,
  output logic                  uart_txd_strobe,
  input  logic                  uart_txd_ready,
  output logic                  trigger,
  output logic [DROP_WIDTH-1:0] dropped,
  output logic                  busy
);

  localparam logic [31:0] ADDR_MASK = (ADDR_BYTES >= 4) ? 32'hFFFF_FFFF
                                                        : ((32'd1 << (8 * ADDR_BYTES)) - 32'd1);
  localparam int TRIG_W = $clog2(TRIGGER_CYCLES + 1);

  state_t                state_q, state_d;
  logic [8*MAX_REC_BYTES-1:0] sreg_q, sreg_d, rec_raw, rec_addr;
  logic [3:0]            cnt_q, cnt_d, rec_len;
  logic                  cap_valid_q, cap_valid_d;
  entry_t                cap_entry_q, cap_entry_d, rd_entry;
  logic [15:0]           mon_count_q, mon_count_d, mon_field;
  logic [TRIG_W-1:0]     trig_cnt_q, trig_cnt_d;
  logic [DROP_WIDTH-1:0] dropped_q, dropped_d;
  logic                  user_fwd_q, user_fwd_d;
  logic [7:0]            user_byte_q, user_byte_d;
  logic                  log_acc, mon_acc, addr_match;
  logic                  fifo_rd, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]    fifo_rd_data;

  assign log_acc    = log_strobe && (mode != FMT_MONITOR);
  assign mon_acc    = mon_strobe && (mode == FMT_MONITOR);
  assign mon_field  = mon_cmd ? 16'h0000 : mon_count_q + 16'd1;
  assign addr_match = (log_addr & ADDR_MASK) == (TRIGGER_ADDR & ADDR_MASK);
  assign rd_entry   = fifo_rd_data;

  spi_log_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .wr_en   (cap_valid_q),
    .wr_data (cap_entry_q),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Event capture, monitor counter, trigger timer and drop counter.
  always_comb begin
    cap_valid_d = log_acc || mon_acc;
    cap_entry_d = cap_entry_q;
    mon_count_d = mon_count_q;
    trig_cnt_d  = trig_cnt_q;
    dropped_d   = dropped_q;
    if (log_acc) begin
      cap_entry_d.fmt = (mode == FMT_VERBOSE) ? FMT_VERBOSE : FMT_COMPACT;
      cap_entry_d.a   = log_addr;
      cap_entry_d.b   = log_len;
    end else if (mon_acc) begin
      cap_entry_d.fmt = FMT_MONITOR;
      cap_entry_d.a   = {mon_field, mon_mosi, mon_miso};
      cap_entry_d.b   = 8'h00;
      mon_count_d     = mon_cmd ? 16'd1 : mon_field;
    end
    if (log_acc && addr_match) trig_cnt_d = TRIG_W'(TRIGGER_CYCLES);
    else if (trig_cnt_q != '0) trig_cnt_d = trig_cnt_q - 1'b1;
    // The full flag is registered, so a push that meets a same-cycle pop is still lost.
    if (cap_valid_q && fifo_full && (dropped_q != '1)) dropped_d = dropped_q + 1'b1;
  end

  // Record formatter: right-aligned bytes, then left-justified into the shifter.
  always_comb begin
    rec_len  = record_len(rd_entry.fmt, ADDR_BYTES);
    rec_addr = (8*MAX_REC_BYTES)'(rd_entry.a & ADDR_MASK);
    case (rd_entry.fmt)
      FMT_VERBOSE: rec_raw = ((8*MAX_REC_BYTES)'(VERBOSE_TAG) << (8 * (ADDR_BYTES + 1)))
                           | (rec_addr << 8) | (8*MAX_REC_BYTES)'(rd_entry.b);
      FMT_MONITOR: rec_raw = (8*MAX_REC_BYTES)'(rd_entry.a);
      default:     rec_raw = (rec_addr << 8) | (8*MAX_REC_BYTES)'(rd_entry.b);
    endcase
  end

  // Serializer next state; IDLE waits for the uart so stalled records stay queued.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    fifo_rd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && uart_txd_ready) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        fifo_rd = 1'b1;
        sreg_d  = rec_raw << (8 * (MAX_REC_BYTES - int'(rec_len)));
        cnt_d   = rec_len;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (uart_txd_ready) begin
          sreg_d = sreg_q << 8;
          cnt_d  = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = fifo_empty ? ST_IDLE : ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // User bytes only pass when no record is pending anywhere in the path.
  always_comb begin
    user_txd_ready = reset_n && (state_q == ST_IDLE) && fifo_empty && !inhibit && uart_txd_ready;
    user_fwd_d     = user_txd_ready && user_txd_strobe;
    user_byte_d    = user_fwd_d ? user_txd : user_byte_q;
  end

  // Output muxing between the record shifter and the forwarded user byte.
  always_comb begin
    uart_txd_strobe = ((state_q == ST_SEND) && uart_txd_ready) || user_fwd_q;
    if (state_q == ST_SEND) uart_txd = sreg_q[8*MAX_REC_BYTES-1 -: 8];
    else if (user_fwd_q)    uart_txd = user_byte_q;
    else                    uart_txd = 8'h00;
    trigger = (trig_cnt_q != '0);
    dropped = dropped_q;
    busy    = !fifo_empty || (state_q != ST_IDLE);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      cap_valid_q <= 1'b0;
      cap_entry_q <= '0;
      mon_count_q <= '0;
      trig_cnt_q  <= '0;
      dropped_q   <= '0;
      user_fwd_q  <= 1'b0;
      user_byte_q <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      cap_valid_q <= cap_valid_d;
      cap_entry_q <= cap_entry_d;
      mon_count_q <= mon_count_d;
      trig_cnt_q  <= trig_cnt_d;
      dropped_q   <= dropped_d;
      user_fwd_q  <= user_fwd_d;
      user_byte_q <= user_byte_d;
    end
  end

endmodule
